// File: rtl/data_path.sv
// data_path: Mini SRC single-bus datapath (register file, special registers, ALU, CON).
// Define MUL_DIV_EN to build the signed multiplier/divider; otherwise MUL/DIV yield 0.
module data_path #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [4:0]       alu_control,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic             R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic             R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic             MDROut, HIout, LOout, ZHIout, ZLOout, Pout, Cout, Yout,
  input  logic             IRen, MARen, MDRen, Yen, Pen, ZHIen, ZLOen, HIen, LOen,
  input  logic             Read,
  input  logic             Write,
  input  logic             R0en, R1en, R2en, R3en, R4en, R5en, R6en, R7en,
  input  logic             R8en, R9en, R10en, R11en, R12en, R13en, R14en, R15en,
  input  logic             Gra, Grb, Grc,
  input  logic             BAout,
  input  logic             ConIn,
  input  logic             Rin, Rout,
  output logic [WIDTH-1:0] bus_out,
  output logic [WIDTH-1:0] mar_out,
  output logic [WIDTH-1:0] mdr_out,
  output logic             mem_write,
  output logic             con_out
);
  logic [WIDTH-1:0] r_q [16];
  logic [WIDTH-1:0] pc_q, mar_q, mdr_q, hi_q, lo_q, y_q, zhi_q, zlo_q;
  logic [WIDTH-1:0] bus, c_sign_ext, mdr_d, a, b;
  // opcode bits are decoded by the external control unit, so only operand fields are held
  logic [26:0] ir_q;
  logic con_q, con_d;
  logic [15:0] rout_v, ren_v, sel_v, drv_v, ld_v;
  logic [3:0] sel;
  logic [4:0] sh;
  logic [2*WIDTH-1:0] res, mul_res, div_res;
  assign rout_v = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                   R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign ren_v = {R15en, R14en, R13en, R12en, R11en, R10en, R9en, R8en,
                  R7en, R6en, R5en, R4en, R3en, R2en, R1en, R0en};
  assign sel = ({4{Gra}} & ir_q[26:23]) | ({4{Grb}} & ir_q[22:19]) | ({4{Grc}} & ir_q[18:15]);
  assign sel_v = 16'd1 << sel;
  assign drv_v = rout_v | ({16{Rout | BAout}} & sel_v);
  assign ld_v = ren_v | ({16{Rin}} & sel_v);
  assign c_sign_ext = {{(WIDTH-19){ir_q[18]}}, ir_q[18:0]};
  // later assignments win, so sources are scanned from lowest to highest priority
  always_comb begin
    bus = '0;
    if (Yout) bus = y_q;
    if (Cout) bus = c_sign_ext;
    if (MDROut) bus = mdr_q;
    if (Pout) bus = pc_q;
    if (ZLOout) bus = zlo_q;
    if (ZHIout) bus = zhi_q;
    if (LOout) bus = lo_q;
    if (HIout) bus = hi_q;
    for (int i = 15; i >= 0; i--)
      if (drv_v[i]) bus = (BAout && sel == 4'd0 && i == 0) ? '0 : r_q[i];
  end
  assign a = y_q;
  assign b = bus;
  assign sh = bus[4:0];
`ifdef MUL_DIV_EN
  logic [WIDTH-1:0] ua, ub, uq, ur, quo, rem;
  assign mul_res = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  // divide magnitudes and restore signs, which avoids the MIN/-1 overflow trap
  assign ua = a[WIDTH-1] ? -a : a;
  assign ub = b[WIDTH-1] ? -b : b;
  assign uq = ua / ub;
  assign ur = ua % ub;
  assign quo = (b == '0) ? '1 : (a[WIDTH-1] ^ b[WIDTH-1]) ? -uq : uq;
  assign rem = (b == '0) ? a : a[WIDTH-1] ? -ur : ur;
  assign div_res = {rem, quo};
`else
  assign mul_res = '0;
  assign div_res = '0;
`endif
  always_comb begin
    res = '0;
    case (alu_control)
      5'b00000: res[WIDTH-1:0] = a + b;
      5'b00001: res[WIDTH-1:0] = a - b;
      5'b00010: res[WIDTH-1:0] = a & b;
      5'b00011: res[WIDTH-1:0] = a | b;
      5'b00100: res[WIDTH-1:0] = a >> sh;
      5'b00101: res[WIDTH-1:0] = $signed(a) >>> sh;
      5'b00110: res[WIDTH-1:0] = a << sh;
      5'b00111: res[WIDTH-1:0] = WIDTH'({a, a} >> sh);
      5'b01000: res[WIDTH-1:0] = WIDTH'(({a, a} << sh) >> WIDTH);
      5'b01001: res = mul_res;
      5'b01010: res = div_res;
      5'b01011: res[WIDTH-1:0] = -b;
      5'b01100: res[WIDTH-1:0] = ~b;
      5'b01101: res[WIDTH-1:0] = b + WIDTH'(1);
      default: res = '0;
    endcase
  end
  assign con_d = ir_q[20] ? (ir_q[19] ? bus[WIDTH-1] : ~bus[WIDTH-1]) : (ir_q[19] ? |bus : ~|bus);
  assign mdr_d = Read ? Mdatain : bus;
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      pc_q <= '0;
      ir_q <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      y_q <= '0;
      zhi_q <= '0;
      zlo_q <= '0;
      con_q <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) if (ld_v[i]) r_q[i] <= bus;
      if (Pen) pc_q <= bus;
      if (IRen) ir_q <= bus[26:0];
      if (MARen) mar_q <= bus;
      if (MDRen) mdr_q <= mdr_d;
      if (HIen) hi_q <= bus;
      if (LOen) lo_q <= bus;
      if (Yen) y_q <= bus;
      if (ZHIen) zhi_q <= res[2*WIDTH-1:WIDTH];
      if (ZLOen) zlo_q <= res[WIDTH-1:0];
      if (ConIn) con_q <= con_d;
    end
  end
  assign bus_out = bus;
  assign mar_out = mar_q;
  assign mdr_out = mdr_q;
  assign mem_write = Write;
  assign con_out = con_q;
endmodule

// File: tb/tb_data_path.sv
// tb_data_path: scoreboard bench for data_path against a spec-level register/ALU model.
module tb_data_path;
  logic clk = 1'b0;
  logic clr;
  logic [4:0] alu_control;
  logic [31:0] Mdatain;
  logic [15:0] rout, ren;
  logic MDROut, HIout, LOout, ZHIout, ZLOout, Pout, Cout, Yout;
  logic IRen, MARen, MDRen, Yen, Pen, ZHIen, ZLOen, HIen, LOen, Read, Write;
  logic Gra, Grb, Grc, BAout, ConIn, Rin, Rout;
  logic [31:0] bus_out, mar_out, mdr_out;
  logic mem_write, con_out;

  data_path dut (
    .clk(clk), .clr(clr), .alu_control(alu_control), .Mdatain(Mdatain),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
    .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
    .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .MDROut(MDROut), .HIout(HIout), .LOout(LOout), .ZHIout(ZHIout), .ZLOout(ZLOout),
    .Pout(Pout), .Cout(Cout), .Yout(Yout),
    .IRen(IRen), .MARen(MARen), .MDRen(MDRen), .Yen(Yen), .Pen(Pen),
    .ZHIen(ZHIen), .ZLOen(ZLOen), .HIen(HIen), .LOen(LOen),
    .Read(Read), .Write(Write),
    .R0en(ren[0]), .R1en(ren[1]), .R2en(ren[2]), .R3en(ren[3]),
    .R4en(ren[4]), .R5en(ren[5]), .R6en(ren[6]), .R7en(ren[7]),
    .R8en(ren[8]), .R9en(ren[9]), .R10en(ren[10]), .R11en(ren[11]),
    .R12en(ren[12]), .R13en(ren[13]), .R14en(ren[14]), .R15en(ren[15]),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .BAout(BAout), .ConIn(ConIn), .Rin(Rin), .Rout(Rout),
    .bus_out(bus_out), .mar_out(mar_out), .mdr_out(mdr_out),
    .mem_write(mem_write), .con_out(con_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int kind;
    logic [31:0] exp;
    int cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [31:0] act;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 bus_out, 1 mar_out, 2 mdr_out, 3 con_out, 4 mem_write
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      act = e.kind == 0 ? bus_out : e.kind == 1 ? mar_out : e.kind == 2 ? mdr_out :
            e.kind == 3 ? {31'd0, con_out} : {31'd0, mem_write};
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.exp, cyc);
      end
    end
  end

  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_hi, m_lo, m_y, m_zhi, m_zlo;
  logic m_con;

  task automatic push(string n, int k, logic [31:0] v);
    sb.push_back('{n, k, v, cyc});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = 0;
    {m_pc, m_ir, m_mar, m_mdr, m_hi, m_lo, m_y, m_zhi, m_zlo} = '0;
    m_con = 1'b0;
  endtask

  task automatic clear_ctl();
    alu_control = 5'd0;
    rout = 16'd0;
    ren = 16'd0;
    {MDROut, HIout, LOout, ZHIout, ZLOout, Pout, Cout, Yout} = '0;
    {IRen, MARen, MDRen, Yen, Pen, ZHIen, ZLOen, HIen, LOen, Read, Write} = '0;
    {Gra, Grb, Grc, BAout, ConIn, Rin, Rout} = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_ctl();
  endtask

  // sources in bus-priority order: 0..15 Rn, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 C, 23 Y
  function automatic logic [31:0] src_val(int s);
    if (s < 16) return m_r[s];
    case (s)
      16: return m_hi;
      17: return m_lo;
      18: return m_zhi;
      19: return m_zlo;
      20: return m_pc;
      21: return m_mdr;
      22: return m_ir[18] ? ({13'd0, m_ir[18:0]} | 32'hFFF80000) : {13'd0, m_ir[18:0]};
      23: return m_y;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive_src(int s);
    if (s < 16) rout[s] = 1'b1;
    else case (s)
      16: HIout = 1'b1;
      17: LOout = 1'b1;
      18: ZHIout = 1'b1;
      19: ZLOout = 1'b1;
      20: Pout = 1'b1;
      21: MDROut = 1'b1;
      22: Cout = 1'b1;
      default: Yout = 1'b1;
    endcase
  endtask

  // destinations: 0..15 Rn, 16 HI, 17 LO, 20 PC, 21 MDR, 23 Y, 24 IR, 25 MAR, other none
  task automatic load_dst(int d, logic [31:0] v);
    if (d < 16) begin ren[d] = 1'b1; m_r[d] = v; end
    else case (d)
      16: begin HIen = 1'b1; m_hi = v; end
      17: begin LOen = 1'b1; m_lo = v; end
      20: begin Pen = 1'b1; m_pc = v; end
      21: begin MDRen = 1'b1; m_mdr = v; end
      23: begin Yen = 1'b1; m_y = v; end
      24: begin IRen = 1'b1; m_ir = v; end
      25: begin MARen = 1'b1; m_mar = v; end
      default: ;
    endcase
  endtask

  task automatic xfer(int s, int d);
    logic [31:0] v;
    v = src_val(s);
    drive_src(s);
    push($sformatf("bus_src%0d", s), 0, v);
    load_dst(d, v);
    tick();
  endtask

  task automatic mem_rd(logic [31:0] v);
    Read = 1'b1;
    MDRen = 1'b1;
    Mdatain = v;
    m_mdr = v;
    tick();
  endtask

  task automatic put(int d, logic [31:0] v);
    mem_rd(v);
    push("mdr_out", 2, v);
    xfer(21, d);
  endtask

  task automatic load_ir(logic [31:0] v);
    mem_rd(v);
    xfer(21, 24);
  endtask

  function automatic logic [3:0] sel_idx(logic [2:0] g);
    return (g[2] ? m_ir[26:23] : 4'd0) | (g[1] ? m_ir[22:19] : 4'd0) | (g[0] ? m_ir[18:15] : 4'd0);
  endfunction

  task automatic sel_out(logic [2:0] g, bit ba, int d);
    logic [3:0] idx;
    logic [31:0] v;
    idx = sel_idx(g);
    v = (ba && idx == 0) ? 32'd0 : m_r[idx];
    {Gra, Grb, Grc} = g;
    if (ba) BAout = 1'b1; else Rout = 1'b1;
    push(ba ? "bus_baout" : "bus_rout", 0, v);
    load_dst(d, v);
    tick();
  endtask

  task automatic sel_in(logic [2:0] g, int s);
    logic [31:0] v;
    v = src_val(s);
    {Gra, Grb, Grc} = g;
    Rin = 1'b1;
    drive_src(s);
    push("bus_rin", 0, v);
    m_r[sel_idx(g)] = v;
    tick();
  endtask

  function automatic logic [63:0] ref_alu(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    int ia = a;
    int ib = b;
    longint la = ia;
    longint lb = ib;
    longint q, rm;
    int unsigned n = b[4:0];
    logic [31:0] r = 32'd0;
    case (op)
      5'd0: r = a + b;
      5'd1: r = a - b;
      5'd2: r = a & b;
      5'd3: r = a | b;
      5'd4: r = a >> n;
      5'd5: r = ia >>> n;
      5'd6: r = a << n;
      5'd7: begin r = a; repeat (n) r = {r[0], r[31:1]}; end
      5'd8: begin r = a; repeat (n) r = {r[30:0], r[31]}; end
`ifdef MUL_DIV_EN
      5'd9: return la * lb;
      5'd10: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        q = la / lb;
        rm = la % lb;
        return {rm[31:0], q[31:0]};
      end
`endif
      5'd11: r = 32'd0 - b;
      5'd12: r = ~b;
      5'd13: r = b + 32'd1;
      default: r = 32'd0;
    endcase
    return {32'd0, r};
  endfunction

  task automatic alu(logic [4:0] op, int s);
    logic [31:0] v;
    v = src_val(s);
    drive_src(s);
    alu_control = op;
    ZHIen = 1'b1;
    ZLOen = 1'b1;
    push("bus_alu_b", 0, v);
    {m_zhi, m_zlo} = ref_alu(op, m_y, v);
    tick();
  endtask

  task automatic con(int s);
    logic [31:0] v;
    v = src_val(s);
    drive_src(s);
    ConIn = 1'b1;
    case (m_ir[20:19])
      2'b00: m_con = (v == 0);
      2'b01: m_con = (v != 0);
      2'b10: m_con = !v[31];
      default: m_con = v[31];
    endcase
    push("bus_con", 0, v);
    tick();
  endtask

  task automatic chk_out();
    Write = 1'($urandom_range(0, 1));
    push("bus_idle", 0, 32'd0);
    push("mar_out", 1, m_mar);
    push("mdr_out", 2, m_mdr);
    push("con_out", 3, {31'd0, m_con});
    push("mem_write", 4, {31'd0, Write});
    tick();
  endtask

  task automatic prio(int s1, int s2);
    drive_src(s1);
    drive_src(s2);
    push($sformatf("prio_%0d_%0d", s1, s2), 0, src_val(s1 < s2 ? s1 : s2));
    tick();
  endtask

  initial begin
    clr = 1'b0;
    Mdatain = 32'd0;
    clear_ctl();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;
    chk_out();
    // asynchronous reset mid-run, observed before the next clock edge
    put(3, 32'h55);
    put(20, 32'h10);
    xfer(3, 26);
    xfer(20, 26);
    rout[3] = 1'b1;
    clr = 1'b0;
    model_reset();
    push("rst_r3", 0, 32'd0);
    push("rst_mar", 1, 32'd0);
    push("rst_mdr", 2, 32'd0);
    push("rst_con", 3, 32'd0);
    tick();
    Pout = 1'b1;
    push("rst_pc", 0, 32'd0);
    tick();
    clr = 1'b1;
    // fetch
    xfer(20, 25);
    mem_rd(32'hA1800000);
    xfer(21, 24);
    chk_out();
    // jump via Ra=3, then BAout with Ra=0
    put(3, 32'h42);
    sel_out(3'b100, 1'b0, 20);
    xfer(20, 26);
    put(0, 32'h99);
    load_ir(32'h0007FFFF);
    sel_out(3'b100, 1'b1, 20);
    xfer(20, 26);
    sel_out(3'b100, 1'b0, 26);
    xfer(22, 26);
    load_ir(32'h0003FFFF);
    xfer(22, 26);
    // ALU
    put(23, 32'd7);
    put(2, 32'd5);
    alu(5'd0, 2);
    xfer(19, 26);
    alu(5'd1, 2);
    xfer(19, 26);
    put(23, 32'h80000000);
    put(2, 32'd2);
    alu(5'd9, 2);
    xfer(18, 26);
    xfer(19, 26);
    put(23, 32'h1234);
    put(2, 32'd0);
    alu(5'd10, 2);
    xfer(18, 26);
    xfer(19, 26);
    put(23, 32'hFFFFFFF9);
    put(2, 32'd2);
    alu(5'd10, 2);
    xfer(18, 26);
    xfer(19, 26);
    // CON
    load_ir(32'h0);
    put(4, 32'd0);
    con(4);
    chk_out();
    load_ir(32'h00180000);
    put(4, 32'h7FFFFFFF);
    con(4);
    chk_out();
    // bus priority and HI/LO
    put(16, 32'hCAFE0001);
    put(17, 32'hBEEF0002);
    prio(2, 23);
    prio(16, 21);
    prio(17, 18);
    prio(19, 20);
    prio(20, 22);
    // randomized traffic
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 7))
        0: put($urandom_range(0, 15), $urandom);
        1: begin
          int d;
          d = $urandom_range(0, 19);
          xfer($urandom_range(0, 23), d == 18 ? 23 : d == 19 ? 25 : d);
        end
        2: put(23, $urandom);
        3: begin
          alu(5'($urandom_range(0, 15)), $urandom_range(0, 15));
          xfer(18, 26);
          xfer(19, 26);
        end
        4: begin
          load_ir($urandom);
          sel_out(3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 1) ? 26 : $urandom_range(0, 15));
        end
        5: sel_in(3'($urandom_range(1, 7)), $urandom_range(0, 23));
        6: con($urandom_range(0, 23));
        default: chk_out();
      endcase
    end
    for (int i = 0; i < 16; i++) xfer(i, 26);
    repeat (3) tick();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
